// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, used by the ALU and the ALU-control decoder.
// The opcode values follow the classic MIPS-style 4-bit ALU control field.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  function automatic logic alu_uses_sub(
    input logic [ALU_OP_W-1:0] op
  );
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  function automatic logic alu_is_arith(
    input logic [ALU_OP_W-1:0] op
  );
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/arithmetic_logic_unit_if.sv
// Bundle between the ALU operation mux and its adder/subtractor.
// The master drives the operands and mode; the slave returns the results.
interface arithmetic_logic_unit_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             lt;

  modport master (
    output a,
    output b,
    output sub,
    input  sum,
    input  ovf,
    input  lt
  );

  modport slave (
    input  a,
    input  b,
    input  sub,
    output sum,
    output ovf,
    output lt
  );

endinterface

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor producing the sum, signed overflow
// and the signed less-than bit.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  arithmetic_logic_unit_if.slave io
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  always_comb begin
    b_eff = io.sub ? ~io.b : io.b;
    sum   = io.a + b_eff
          + {{(WIDTH-1){1'b0}}, io.sub};
    // Same-sign inputs giving a different-sign sum cannot be represented.
    ovf   = (io.a[WIDTH-1] == b_eff[WIDTH-1])
         && (sum[WIDTH-1] != io.a[WIDTH-1]);
  end

  assign io.sum = sum;
  assign io.ovf = ovf;
  // The sign of A-B is wrong exactly when the subtraction overflowed.
  assign io.lt  = sum[WIDTH-1] ^ ovf;

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Single-cycle ALU with a sticky overflow flag.
// Define ALU_OUT_REG_EN to register OUT, zero and overflow (1-cycle latency).
module arithmetic_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] OP,
  output logic [WIDTH-1:0]    OUT,
  output logic                zero,
  output logic                overflow,
  output logic                ovf_sticky
);

  arithmetic_logic_unit_if #(
    .WIDTH(WIDTH)
  ) as_if ();

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .io(as_if)
  );

  assign as_if.a   = A;
  assign as_if.b   = B;
  assign as_if.sub = alu_uses_sub(OP);

  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unique case (OP)
      ALU_AND: res_c = A & B;
      ALU_OR:  res_c = A | B;
      ALU_NOR: res_c = ~(A | B);
      ALU_ADD,
      ALU_SUB: begin
        res_c = as_if.sum;
        ovf_c = as_if.ovf;
      end
      ALU_SLT: res_c = {{(WIDTH-1){1'b0}}, as_if.lt};
      default: begin
        res_c = '0;
        ovf_c = 1'b0;
      end
    endcase
  end

  logic sticky_set;

`ifdef ALU_OUT_REG_EN
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             zero_q;
  logic             zero_d;
  logic             ovf_q;
  logic             ovf_d;

  always_comb begin
    out_d  = res_c;
    zero_d = (res_c == '0);
    ovf_d  = ovf_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign OUT        = out_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;
  assign sticky_set = ovf_q;
`else
  assign OUT        = res_c;
  assign zero       = (res_c == '0);
  assign overflow   = ovf_c;
  assign sticky_set = ovf_c;
`endif

  logic sticky_q;
  logic sticky_d;

  assign sticky_d = sticky_q | sticky_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Randomized self-checking bench for arithmetic_logic_unit.
// Reference model computes results with wide signed integer arithmetic.
module tb_arithmetic_logic_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  OP;
  logic [31:0] OUT;
  logic        zero;
  logic        overflow;
  logic        ovf_sticky;

  int n_vec;
  int n_err;

  // model state
  logic        sticky_m;
  logic [31:0] out_reg_m;
  logic        zero_reg_m;
  logic        ovf_reg_m;

  arithmetic_logic_unit #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .OUT       (OUT),
    .zero      (zero),
    .overflow  (overflow),
    .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] r,
    output logic        v
  );
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r  = 32'h0;
    v  = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010, 4'b0110: begin
        s = (op == 4'b0010) ? sa + sb : sa - sb;
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
  endfunction

  task automatic apply(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  op
  );
    logic [31:0] r;
    logic        v;
    model(a, b, op, r, v);
    A  = a;
    B  = b;
    OP = op;
`ifdef ALU_OUT_REG_EN
    #1;
    chk("out_hold", OUT, out_reg_m);
    @(posedge clk);
    #1;
    sticky_m   = sticky_m | ovf_reg_m;
    out_reg_m  = r;
    zero_reg_m = (r == 32'h0);
    ovf_reg_m  = v;
    chk("out", OUT, r);
    chk("zero", {31'h0, zero}, {31'h0, zero_reg_m});
    chk("ovf", {31'h0, overflow}, {31'h0, v});
    chk("sticky", {31'h0, ovf_sticky}, {31'h0, sticky_m});
`else
    #1;
    chk("out", OUT, r);
    chk("zero", {31'h0, zero}, {31'h0, r == 32'h0});
    chk("ovf", {31'h0, overflow}, {31'h0, v});
    @(posedge clk);
    #1;
    sticky_m = sticky_m | v;
    chk("sticky", {31'h0, ovf_sticky}, {31'h0, sticky_m});
`endif
  endtask

  task automatic do_reset();
    logic [31:0] r;
    logic        v;
    model(A, B, OP, r, v);
    reset = 1'b1;
`ifndef ALU_OUT_REG_EN
    #1;
    chk("rst_out", OUT, r);
    chk("rst_ovf", {31'h0, overflow}, {31'h0, v});
`endif
    @(posedge clk);
    #1;
    sticky_m   = 1'b0;
    out_reg_m  = 32'h0;
    zero_reg_m = 1'b1;
    ovf_reg_m  = 1'b0;
    chk("rst_sticky", {31'h0, ovf_sticky}, 32'h0);
`ifdef ALU_OUT_REG_EN
    chk("rst_out", OUT, 32'h0);
    chk("rst_zero", {31'h0, zero}, 32'h1);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
`endif
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [6];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'hFFFF_FFFF;
    corner[5] = 32'h8000_0001;
    if ($urandom_range(3) == 0) begin
      return corner[$urandom_range(5)];
    end
    return $urandom;
  endfunction

  initial begin
    logic [3:0] ops [7];
    ops[0] = 4'b0000;
    ops[1] = 4'b0001;
    ops[2] = 4'b0010;
    ops[3] = 4'b0110;
    ops[4] = 4'b0111;
    ops[5] = 4'b1100;
    ops[6] = 4'b1111;
    n_vec      = 0;
    n_err      = 0;
    sticky_m   = 1'b0;
    out_reg_m  = 32'h0;
    zero_reg_m = 1'b1;
    ovf_reg_m  = 1'b0;
    reset      = 1'b1;
    A          = 32'h0;
    B          = 32'h0;
    OP         = 4'b0000;
    @(negedge clk);
    do_reset();

    apply(32'h0000_0000, 32'h4, 4'b0010);
    apply(32'h1234_5678, 32'h1234_5678, 4'b0110);
    apply(32'hFFFF_FFFF, 32'h1, 4'b0111);
    apply(32'h8000_0000, 32'h1, 4'b0111);
    apply(32'h0000_0001, 32'h8000_0000, 4'b0111);
    apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000);
    apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0001);
    apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1100);
    apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1111);
    apply(32'h0000_0002, 32'h0000_0003, 4'b0010);

    apply(32'h7FFF_FFFF, 32'h1, 4'b0010);
    apply(32'h0, 32'h0, 4'b0010);
    apply(32'h0, 32'h0, 4'b0000);
    chk("sticky_hold", {31'h0, ovf_sticky}, 32'h1);
    apply(32'h8000_0000, 32'h1, 4'b0110);
    do_reset();
    apply(32'h0, 32'h0, 4'b0000);

    for (int i = 0; i < 300; i++) begin
      apply(pick(), pick(), ops[$urandom_range(6)]);
      if ($urandom_range(40) == 0) begin
        do_reset();
      end
    end
    for (int i = 0; i < 16; i++) begin
      apply(pick(), pick(), 4'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
